// File: rtl/sdp_ram_pkg.sv
// Shared types and helpers for the sdp_ram_clear RAM: FSM state, lane count and address sizing.
package sdp_ram_pkg;

   typedef enum logic {
      ST_CLEAR,
      ST_RUN
   } state_t;

   function automatic int lanes(input int width, input int lane_w);
      return width / lane_w;
   endfunction

   function automatic int addr_bits(input int entries);
      return (entries <= 2) ? 1 : $clog2(entries);
   endfunction

   // Guards the non-power-of-two case where an address can point past the last entry
   function automatic logic addr_ok(input int addr, input int entries);
      return addr < entries;
   endfunction

endpackage

// File: rtl/sdp_ram_lane.sv
// One LANE_W-wide slice of the RAM: a single write port and a registered read port.
// Out-of-range writes are dropped and out-of-range reads return zero.
module sdp_ram_lane
   import sdp_ram_pkg::*;
#(
   parameter int LANE_W  = 8,
   parameter int ENTRIES = 16,
   parameter int AW      = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [LANE_W-1:0] wdata,
   input  logic              re,
   input  logic [AW-1:0]     raddr,
   output logic [LANE_W-1:0] rdata
);

   logic [LANE_W-1:0] mem [ENTRIES];

   always_ff @(posedge clk) begin
      if (we && addr_ok(int'(waddr), ENTRIES)) begin
         mem[waddr] <= wdata;
      end
   end

   // Reads see the pre-edge contents; the top patches in same-cycle write data
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (re) begin
         if (addr_ok(int'(raddr), ENTRIES)) begin
            rdata <= mem[raddr];
         end else begin
            rdata <= '0;
         end
      end
   end

endmodule

// File: rtl/sdp_ram_clear.sv
// Simple dual-port RAM with byte-lane writes, write-first forwarding and a post-reset clear sequencer.
// Define SDP_RAM_OUTREG_EN to add a second output register stage (read latency 2).
module sdp_ram_clear
   import sdp_ram_pkg::*;
#(
   parameter int                WIDTH       = 32,
   parameter int                ENTRIES     = 16,
   parameter int                LANE_W      = 8,
   parameter logic [WIDTH-1:0]  CLEAR_VALUE = '0,
   localparam int               LANES       = lanes(WIDTH, LANE_W),
   localparam int               AW          = addr_bits(ENTRIES)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [AW-1:0]     waddr,
   input  logic [WIDTH-1:0]  write_data,
   input  logic [LANES-1:0]  write_be,
   input  logic              write_enable,
   input  logic [AW-1:0]     raddr,
   input  logic              read_enable,
   output logic [WIDTH-1:0]  read_data,
   output logic              read_valid,
   output logic              init_busy
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(ENTRIES - 1);

   state_t           state;
   logic [AW-1:0]    clr_cnt;
   logic [LANES-1:0] lane_we;
   logic [AW-1:0]    lane_waddr;
   logic [WIDTH-1:0] lane_wdata;
   logic             issue;
   logic             same_addr;
   logic [LANES-1:0] lane_hit;
   logic [LANES-1:0] fwd_q;
   logic [WIDTH-1:0] fwd_data_q;
   logic [WIDTH-1:0] lane_q;
   logic [WIDTH-1:0] stage1_data;
   logic             stage1_valid;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_CLEAR;
         clr_cnt   <= '0;
         init_busy <= 1'b1;
      end else if (state == ST_CLEAR) begin
         if (clr_cnt == LAST_ADDR) begin
            state     <= ST_RUN;
            init_busy <= 1'b0;
         end else begin
            clr_cnt <= clr_cnt + 1'b1;
         end
      end
   end

   // The clear sequencer owns the write port until RUN; user traffic is ignored meanwhile
   always_comb begin
      lane_we    = '0;
      lane_waddr = waddr;
      lane_wdata = write_data;
      if (state == ST_CLEAR) begin
         lane_we    = '1;
         lane_waddr = clr_cnt;
         lane_wdata = CLEAR_VALUE;
      end else if (write_enable) begin
         lane_we = write_be;
      end
   end

   assign issue     = (state == ST_RUN) && read_enable;
   assign same_addr = write_enable && (waddr == raddr) && addr_ok(int'(raddr), ENTRIES);
   assign lane_hit  = same_addr ? write_be : '0;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      sdp_ram_lane #(
         .LANE_W  (LANE_W),
         .ENTRIES (ENTRIES),
         .AW      (AW)
      ) u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .we    (lane_we[i]),
         .waddr (lane_waddr),
         .wdata (lane_wdata[i*LANE_W +: LANE_W]),
         .re    (issue),
         .raddr (raddr),
         .rdata (lane_q[i*LANE_W +: LANE_W])
      );
   end

   // Forwarding decisions are captured at issue so the result holds while reads are idle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stage1_valid <= 1'b0;
         fwd_q        <= '0;
         fwd_data_q   <= '0;
      end else begin
         stage1_valid <= issue;
         if (issue) begin
            fwd_q      <= lane_hit;
            fwd_data_q <= write_data;
         end
      end
   end

   always_comb begin
      stage1_data = lane_q;
      for (int i = 0; i < LANES; i++) begin
         if (fwd_q[i]) begin
            stage1_data[i*LANE_W +: LANE_W] = fwd_data_q[i*LANE_W +: LANE_W];
         end
      end
   end

`ifdef SDP_RAM_OUTREG_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         read_data  <= '0;
         read_valid <= 1'b0;
      end else begin
         read_valid <= stage1_valid;
         if (stage1_valid) begin
            read_data <= stage1_data;
         end
      end
   end
`else
   always_comb begin
      read_data  = stage1_data;
      read_valid = stage1_valid;
   end
`endif

endmodule

// File: tb/tb_sdp_ram_clear.sv
// Scoreboard bench for sdp_ram_clear: a 16-entry instance and a 12-entry instance share one stimulus stream.
module tb_sdp_ram_clear;

   localparam int          E16  = 16;
   localparam int          E12  = 12;
   localparam logic [31:0] CV16 = 32'hA5A5A5A5;
   localparam logic [31:0] CV12 = 32'h0;
`ifdef SDP_RAM_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  waddr;
   logic [31:0] write_data;
   logic [3:0]  write_be;
   logic        write_enable;
   logic [3:0]  raddr;
   logic        read_enable;
   logic [31:0] rd16, rd12;
   logic        rv16, rv12, busy16, busy12;

   logic [31:0] mem16 [E16];
   logic [31:0] mem12 [E12];
   logic [31:0] q16 [$];
   logic [31:0] q12 [$];
   logic [31:0] last16, last12;
   logic [1:0]  vp16, vp12;
   int          clr16, clr12;
   int          checks, errors;
   bit          mon_en;

   always #5 clk = ~clk;

   sdp_ram_clear #(.WIDTH(32), .ENTRIES(E16), .LANE_W(8), .CLEAR_VALUE(CV16)) dut16 (
      .clk(clk), .rst_n(rst_n), .waddr(waddr), .write_data(write_data), .write_be(write_be),
      .write_enable(write_enable), .raddr(raddr), .read_enable(read_enable),
      .read_data(rd16), .read_valid(rv16), .init_busy(busy16)
   );

   sdp_ram_clear #(.WIDTH(32), .ENTRIES(E12), .LANE_W(8), .CLEAR_VALUE(CV12)) dut12 (
      .clk(clk), .rst_n(rst_n), .waddr(waddr), .write_data(write_data), .write_be(write_be),
      .write_enable(write_enable), .raddr(raddr), .read_enable(read_enable),
      .read_data(rd12), .read_valid(rv12), .init_busy(busy12)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic hit,
                                         input logic [31:0] wd, input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) begin
         if (hit && be[i]) r[i*8 +: 8] = wd[i*8 +: 8];
      end
      return r;
   endfunction

   // One clock of stimulus: expected read results are queued at issue, the memory model updated at the edge
   task automatic applyStimulus(input logic r, input logic we, input logic [3:0] wa, input logic [31:0] wd,
                                input logic [3:0] be, input logic re, input logic [3:0] ra);
      logic iss16, iss12;
      rst_n        = r;
      write_enable = we;
      waddr        = wa;
      write_data   = wd;
      write_be     = be;
      read_enable  = re;
      raddr        = ra;
      iss16 = r && re && (clr16 == 0);
      iss12 = r && re && (clr12 == 0);
      if (iss16) q16.push_back(merge(mem16[ra], we && (wa == ra), wd, be));
      if (iss12) begin
         if (int'(ra) >= E12) q12.push_back(32'h0);
         else q12.push_back(merge(mem12[ra], we && (wa == ra), wd, be));
      end
      @(posedge clk);
      if (!r) begin
         clr16 = E16;
         clr12 = E12;
         vp16 = '0;
         vp12 = '0;
         q16.delete();
         q12.delete();
         last16 = '0;
         last12 = '0;
      end else begin
         if (clr16 > 0) begin
            mem16[E16 - clr16] = CV16;
            clr16--;
         end else if (we) begin
            mem16[wa] = merge(mem16[wa], 1'b1, wd, be);
         end
         if (clr12 > 0) begin
            mem12[E12 - clr12] = CV12;
            clr12--;
         end else if (we && int'(wa) < E12) begin
            mem12[wa] = merge(mem12[wa], 1'b1, wd, be);
         end
         vp16 = {vp16[0], iss16};
         vp12 = {vp12[0], iss12};
      end
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         checkOutput("busy16", 32'(busy16), 32'(clr16 > 0));
         checkOutput("busy12", 32'(busy12), 32'(clr12 > 0));
         checkOutput("valid16", 32'(rv16), 32'(vp16[LAT-1]));
         checkOutput("valid12", 32'(rv12), 32'(vp12[LAT-1]));
         if (vp16[LAT-1] && q16.size() > 0) last16 = q16.pop_front();
         if (vp12[LAT-1] && q12.size() > 0) last12 = q12.pop_front();
         checkOutput("data16", rd16, last16);
         checkOutput("data12", rd12, last12);
      end
   end

   initial begin
      checks = 0;
      errors = 0;
      mon_en = 1'b0;
      clr16  = E16;
      clr12  = E12;
      vp16   = '0;
      vp12   = '0;
      last16 = '0;
      last12 = '0;

      // reset, partial clear, reset again mid-clear
      applyStimulus(1'b0, 1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0);
      mon_en = 1'b1;
      applyStimulus(1'b0, 1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0);
      idle(7);
      applyStimulus(1'b0, 1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0);
      applyStimulus(1'b0, 1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0);

      // busy window: write and read attempts are ignored
      applyStimulus(1'b1, 1'b1, 4'd3, 32'h12345678, 4'hF, 1'b1, 4'd3);
      applyStimulus(1'b1, 1'b1, 4'd3, 32'h12345678, 4'hF, 1'b0, 4'd0);
      idle(15);

      // back-to-back reads of every address after clear
      for (int a = 0; a < 16; a++) applyStimulus(1'b1, 1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'(a));
      idle(2);

      // byte-lane enables
      applyStimulus(1'b1, 1'b1, 4'd5, 32'h11223344, 4'hF, 1'b0, 4'd0);
      applyStimulus(1'b1, 1'b1, 4'd5, 32'hAABBCCDD, 4'b0101, 1'b0, 4'd0);
      applyStimulus(1'b1, 1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd5);
      idle(2);

      // write-first collision, then a plain re-read
      applyStimulus(1'b1, 1'b1, 4'd9, 32'h0, 4'hF, 1'b0, 4'd0);
      applyStimulus(1'b1, 1'b1, 4'd9, 32'hDEADBEEF, 4'b1100, 1'b1, 4'd9);
      applyStimulus(1'b1, 1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd9);
      idle(2);

      // a write landing one cycle after issue must not reach that read
      applyStimulus(1'b1, 1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd7);
      applyStimulus(1'b1, 1'b1, 4'd7, 32'h12345678, 4'hF, 1'b0, 4'd0);
      applyStimulus(1'b1, 1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd7);
      idle(2);

      // valid pulse and data hold
      applyStimulus(1'b1, 1'b1, 4'd2, 32'h5, 4'hF, 1'b0, 4'd0);
      applyStimulus(1'b1, 1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd2);
      idle(3);

      // out-of-range address on the 12-entry instance
      applyStimulus(1'b1, 1'b1, 4'd13, 32'hFFFFFFFF, 4'hF, 1'b0, 4'd0);
      applyStimulus(1'b1, 1'b1, 4'd13, 32'h0F0F0F0F, 4'hF, 1'b1, 4'd13);
      for (int a = 0; a < 12; a++) applyStimulus(1'b1, 1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'(a));
      idle(2);

      // mixed random traffic
      for (int i = 0; i < 40; i++) begin
         applyStimulus(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 32'($urandom),
                       4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)));
      end
      idle(3);

      // reset in RUN restarts the clear
      applyStimulus(1'b0, 1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0);
      idle(16);
      applyStimulus(1'b1, 1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd5);
      applyStimulus(1'b1, 1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd9);
      idle(3);

      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sdp_ram_clear.md
Name: sdp_ram_clear

Overview:
Single-clock simple dual-port RAM with byte-lane write enables, read enable with valid flag, and write-first collision forwarding. Includes a hardware clear sequencer: after every reset it writes CLEAR_VALUE to all entries before accepting traffic. Used as the general buffer/lookup RAM in single-clock datapaths that need deterministic contents after reset.

Parameters:
WIDTH, 32, word size in bits; must be a multiple of LANE_W.
ENTRIES, 16, number of words; must be at least 2; need not be a power of two.
LANE_W, 8, bits per write-enable lane; LANES = WIDTH/LANE_W.
CLEAR_VALUE, 0, WIDTH-bit value written to every entry during clear.

Ports:
clk  input  1  the only clock
rst_n  input  1  synchronous active-low reset
waddr  input  $clog2(ENTRIES)  write address
write_data  input  WIDTH  write data
write_be  input  LANES  per-lane write enable; lane i covers bits [i*LANE_W +: LANE_W]
write_enable  input  1  1 = write the enabled lanes this cycle
raddr  input  $clog2(ENTRIES)  read address
read_enable  input  1  1 = issue a read this cycle
read_data  output  WIDTH  registered read result
read_valid  output  1  1 = read_data holds the result of a read issued last cycle
init_busy  output  1  1 = clear sequence in progress; user ports ignored

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low.
- Reset values: read_data = 0, read_valid = 0, init_busy = 1, FSM = CLEAR, clear counter = 0.
- FSM CLEAR: each cycle write CLEAR_VALUE to all lanes at counter, then increment. At counter = ENTRIES-1, write and go to RUN. init_busy deasserts in the first RUN cycle. The clear takes exactly ENTRIES cycles after rst_n rises.
- In CLEAR, write_enable and read_enable are ignored. No user writes occur, and read_valid stays 0.
- rst_n low in mid-clear or in RUN restarts the clear from address 0. Contents are not otherwise defined during reset.
- FSM RUN is the terminal state until the next reset.
- Write in RUN: lane i of mem[waddr] is updated at the clock edge iff write_enable & write_be[i]. Lanes not enabled keep their value. write_enable with write_be = 0 is a no-op.
- Read in RUN: latency 1. With read_enable = 1 at edge N, read_data = mem[raddr] and read_valid = 1 after edge N. With read_enable = 0, read_valid = 0 and read_data holds its previous value.
- Collision (read_enable & write_enable & raddr == waddr in the same cycle): write-first per lane. Enabled lanes return write_data; other lanes return the stored value. No undefined result.
- Out-of-range addresses (>= ENTRIES, non-power-of-two ENTRIES only):
  - A write is dropped.
  - A read returns all zeros with read_valid = 1.
  - No forwarding is applied.
- Back-to-back reads every cycle are supported. Throughput is one read and one write per cycle.

Optional Feature:
Macro SDP_RAM_OUTREG_EN.
- Defined: adds a second output register stage. Read latency becomes 2, and read_valid is delayed with the data. Both stages reset to 0. Forwarding is resolved at issue, so a write in the cycle between the stages is not reflected in the read.
- Undefined: latency 1 as above.
- init_busy timing is identical in both builds.

Decomposition:
- Package sdp_ram_pkg holds:
  - State enum (CLEAR, RUN).
  - Function lanes(WIDTH, LANE_W).
  - Function for the address-width calculation.
- One sub-module, sdp_ram_lane: a single LANE_W-wide memory array with its own write enable and registered read. It is instantiated LANES times via generate.
- The top holds the FSM, the clear counter, forwarding muxes, valid tracking and the optional output stage.

Test Plan:
- Clear: with CLEAR_VALUE = 32'hA5A5A5A5, release rst_n. init_busy stays high for exactly 16 cycles. Then reading addresses 0..15 returns 32'hA5A5A5A5 with read_valid one cycle after each read_enable.
- Mid-clear reset: assert rst_n low at clear cycle 7, then release. init_busy stays high for a full 16 cycles after release. A write issued during busy to addr 3 (32'h12345678) is ignored, and addr 3 reads CLEAR_VALUE.
- Byte enables: write 32'h11223344 with be = 4'hF to addr 5, then 32'hAABBCCDD with be = 4'b0101. Reading addr 5 returns 32'h11BB33DD.
- Collision: addr 9 holds 32'h0; in one cycle write 32'hDEADBEEF with be = 4'b1100 and read addr 9. read_data = 32'hDEAD0000 next cycle. A read of addr 9 in the following cycle also returns 32'hDEAD0000.
- Valid/hold: read addr 2 (holding 32'h5), then deassert read_enable for 3 cycles. read_valid pulses for 1 cycle and read_data holds 32'h5. With ENTRIES = 12, a read of addr 13 returns 0 with read_valid = 1, and a write to addr 13 changes no entry.
- SDP_RAM_OUTREG_EN build: repeat the collision and back-to-back read tests. Data and read_valid appear 2 cycles after issue. A write to the read address one cycle after issue is not reflected.
